regfile_debug_dumper: RTL and testbench

Reader on the register file's debug port (debug_addr/debug_data).
- On a start pulse, sweeps registers 0..31 and captures each word.
- Emits a byte-framed dump over a valid/ready byte stream, which feeds the board UART/debug link.
- Keeps the existing 5-bit debug address / 32-bit combinational debug data interface, and is the consumer side of it.

---
 rtl/regfile_debug_pkg.sv | 22 ++
 rtl/regfile_debug_dumper.sv | 134 +++++++++++++
 tb/tb_regfile_debug_dumper.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_debug_pkg.sv
// Shared types and defaults for the register-file debug dumper.
package regfile_debug_pkg;

    localparam int         DEFAULT_NUM_REGS = 32;
    localparam int         DEFAULT_ADDR_W   = 5;
    localparam int         DEFAULT_DATA_W   = 32;
    localparam logic [7:0] DEFAULT_HEADER   = 8'hA5;

    // Header + (address byte + data bytes) per register + checksum.
    localparam int FRAME_BYTES = 1 + DEFAULT_NUM_REGS * (1 + DEFAULT_DATA_W / 8) + 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        CAP,
        DATA,
        CSUM,
        DONE
    } dumpState_t;

endpackage

// File: rtl/regfile_debug_dumper.sv
// Sweeps the register file debug port and streams a byte-framed dump:
// header, {address, data MSB-first} per register, then an XOR checksum.
module regfile_debug_dumper
    import regfile_debug_pkg::*;
#(
    parameter int         NUM_REGS = DEFAULT_NUM_REGS,
    parameter int         ADDR_W   = DEFAULT_ADDR_W,
    parameter int         DATA_W   = DEFAULT_DATA_W,
    parameter logic [7:0] HEADER   = DEFAULT_HEADER
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int                BYTES     = DATA_W / 8;
    localparam int                BCNT_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

    dumpState_t        state;
    logic [ADDR_W-1:0] idx;
    logic [BCNT_W-1:0] byteCnt;
    logic [DATA_W-1:0] shiftReg;
    logic [DATA_W-1:0] nextWord;
    logic [7:0]        csum;
    logic              xfer;

    assign xfer     = tx_valid && tx_ready;
    assign nextWord = shiftReg << 8;

    function automatic logic [7:0] addrByte(input logic [ADDR_W-1:0] a);
        return 8'(a);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            byteCnt  <= '0;
            shiftReg <= '0;
            csum     <= '0;
            dbg_addr <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HDR;
                        idx      <= '0;
                        csum     <= '0;
                        byteCnt  <= '0;
                        tx_data  <= HEADER;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state    <= ADDR;
                        dbg_addr <= idx;
                        tx_data  <= addrByte(idx);
                    end
                end
                ADDR: begin
                    if (xfer) begin
                        csum     <= csum ^ tx_data;
                        tx_valid <= 1'b0;
                        state    <= CAP;
                    end
                end
                // dbg_addr has been stable since ADDR was entered, so the
                // combinational read data is settled for this capture.
                CAP: begin
                    shiftReg <= dbg_data;
                    tx_data  <= dbg_data[DATA_W-1 -: 8];
                    tx_valid <= 1'b1;
                    byteCnt  <= '0;
                    state    <= DATA;
                end
                DATA: begin
                    if (xfer) begin
                        csum     <= csum ^ tx_data;
                        shiftReg <= nextWord;
                        byteCnt  <= byteCnt + 1'b1;
                        if (byteCnt == LAST_BYTE) begin
                            if (idx == LAST_IDX) begin
                                tx_data <= csum ^ tx_data;
                                state   <= CSUM;
                            end else begin
                                idx      <= idx + 1'b1;
                                dbg_addr <= idx + 1'b1;
                                tx_data  <= addrByte(idx + 1'b1);
                                state    <= ADDR;
                            end
                        end else begin
                            tx_data <= nextWord[DATA_W-1 -: 8];
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_debug_dumper.sv
// Scoreboard bench for regfile_debug_dumper: stimulus pushes expected bytes,
// a monitor pops and compares every transferred byte.
module tb_regfile_debug_dumper;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        start    = 1'b0;
    logic        tx_ready = 1'b1;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    logic [31:0] regs    [32];
    logic [31:0] expWord [32];
    logic [7:0]  expQ[$];
    int          passCnt  = 0;
    int          totalCnt = 0;
    int          doneCnt  = 0;
    int          byteIdx  = 0;
    logic        rndReady = 1'b0;

    always #5 clock = ~clock;

    // Register file debug port model: register 0 always reads zero.
    assign dbg_data = (dbg_addr == 5'd0) ? 32'h0 : regs[dbg_addr];

    regfile_debug_dumper dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: byte scoreboard, stall stability, done pulse counting.
    initial begin : monitor
        logic       prevStall;
        logic [7:0] prevData;
        logic [7:0] expB;
        prevStall = 1'b0;
        prevData  = 8'h0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall)
                    check("stall_hold", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, prevData});
                if (done) doneCnt++;
                if (tx_valid && tx_ready) begin
                    if (expQ.size() == 0) begin
                        totalCnt++;
                        $display("FAIL extra_byte: got %h, expected no byte", tx_data);
                    end else begin
                        expB = expQ.pop_front();
                        check($sformatf("tx_byte[%0d]", byteIdx), {24'b0, tx_data}, {24'b0, expB});
                    end
                    byteIdx++;
                end
                prevStall = tx_valid && !tx_ready;
                prevData  = tx_data;
            end
        end
    end

    initial begin : readyDriver
        forever begin
            @(posedge clock);
            #1;
            tx_ready = rndReady ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic clearWords();
        for (int r = 0; r < 32; r++) begin
            regs[r]    = 32'h0;
            expWord[r] = 32'h0;
        end
    endtask

    task automatic pushFrame(input logic [7:0] csum);
        byteIdx = 0;
        expQ.push_back(8'hA5);
        for (int r = 0; r < 32; r++) begin
            expQ.push_back(8'(r));
            for (int b = 3; b >= 0; b--) expQ.push_back(expWord[r][8*b +: 8]);
        end
        expQ.push_back(csum);
    endtask

    task automatic pulseStart();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, "_done_in_budget"}, {31'b0, n < budget}, 32'd1);
    endtask

    task automatic endFrame(input string name, input int doneBefore);
        repeat (3) @(negedge clock);
        check({name, "_queue_empty"}, expQ.size(), 32'd0);
        check({name, "_done_once"}, doneCnt - doneBefore, 32'd1);
        check({name, "_idle"}, {30'b0, busy, tx_valid}, 32'd0);
    endtask

    initial begin : stimulus
        int doneAt;
        int d0;
        int n;
        logic busyOk;

        clearWords();
        #12;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("rst_busy_done", {30'b0, busy, done}, 32'd0);
        check("rst_dbg_addr", {27'b0, dbg_addr}, 32'd0);
        reset = 1'b1;

        // T1: all zero, exact timing with ready held high.
        clearWords();
        pushFrame(8'h00);
        d0 = doneCnt;
        doneAt = -1;
        @(posedge clock);
        #1 start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (c == 1) begin
                start = 1'b0;
                check("t1_busy_hdr", {31'b0, busy}, 32'd1);
            end
            if (done && doneAt < 0) doneAt = c;
            if (doneAt >= 0 && c == doneAt + 1) begin
                check("t1_idle_after_done", {31'b0, busy}, 32'd0);
                break;
            end
        end
        check("t1_done_cycle", doneAt, 32'd195);
        check("t1_dbg_addr_hold", {27'b0, dbg_addr}, 32'd31);
        endFrame("t1", d0);

        // T2: register 1 pattern, register 0 forced to zero by the file.
        clearWords();
        regs[0] = 32'hFFFF_FFFF;
        regs[1] = 32'h1234_5678;
        expWord[1] = 32'h1234_5678;
        pushFrame(8'h08);
        d0 = doneCnt;
        pulseStart();
        waitDone("t2", 1000);
        endFrame("t2", d0);

        // T3: same frame under random backpressure.
        pushFrame(8'h08);
        d0 = doneCnt;
        rndReady = 1'b1;
        pulseStart();
        waitDone("t3", 3000);
        rndReady = 1'b0;
        endFrame("t3", d0);

        // T4: start re-pulsed mid-frame is ignored.
        clearWords();
        pushFrame(8'h00);
        d0 = doneCnt;
        doneAt = -1;
        busyOk = 1'b1;
        @(posedge clock);
        #1 start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (c == 1 || c == 11 || c == 101) start = 1'b0;
            if (c == 10 || c == 100) start = 1'b1;
            if (c >= 1 && doneAt < 0 && !busy) busyOk = 1'b0;
            if (done && doneAt < 0) doneAt = c;
            if (doneAt >= 0 && c == doneAt + 1) break;
        end
        check("t4_busy_held", {31'b0, busyOk}, 32'd1);
        check("t4_done_cycle", doneAt, 32'd195);
        endFrame("t4", d0);

        // T5: register 5 written between its address byte and its capture.
        clearWords();
        regs[5] = 32'h1111_1111;
        expWord[5] = 32'hDEAD_BEEF;
        pushFrame(8'h22);
        d0 = doneCnt;
        pulseStart();
        n = 0;
        while (!(tx_valid && tx_ready && tx_data == 8'h05) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("t5_saw_addr5", {31'b0, n < 200}, 32'd1);
        @(posedge clock);
        #1 regs[5] = 32'hDEAD_BEEF;
        waitDone("t5", 1000);
        endFrame("t5", d0);

        // T6: asynchronous reset during DATA of register 7, then a fresh frame.
        clearWords();
        regs[1] = 32'h1234_5678;
        expWord[1] = 32'h1234_5678;
        pushFrame(8'h08);
        pulseStart();
        repeat (46) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("t6_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("t6_rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_dbg_addr", {27'b0, dbg_addr}, 32'd0);
        expQ.delete();
        #3 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("t6_stays_idle", {30'b0, busy, tx_valid}, 32'd0);
        pushFrame(8'h08);
        d0 = doneCnt;
        pulseStart();
        waitDone("t6", 1000);
        endFrame("t6", d0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
